// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock LSB first through one full-subtractor cell.
// Optional SERIAL_SUB_OVF_EN adds a registered two's-complement overflow output Ovf_o.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] D_o,
    output logic             Bout_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf_o
`endif
);

    localparam int CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             a_bit, b_bit, d_bit, br_next, last;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb;
`endif

    // Returns {borrow_out, difference} for a single bit position.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
        full_sub = {(~a & b) | (~(a ^ b) & bin), a ^ b ^ bin};
    endfunction

    assign a_bit            = a_sr[0];
    assign b_bit            = b_sr[0];
    assign {br_next, d_bit} = full_sub(a_bit, b_bit, br);
    assign last             = (cnt == CNT_LAST);

    assign busy_o = (state == RUN);
    assign done_o = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            D_o    <= '0;
            Bout_o <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            Ovf_o  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_sr <= A_i;
                        b_sr <= B_i;
                        br   <= Bin_i;
                        cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= A_i[WIDTH-1];
                        b_msb <= B_i[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    br     <= br_next;
                    cnt    <= cnt + CNT_W'(1);
                    // The final bit is folded in directly so outputs update on the RUN->DONE edge.
                    if (last) begin
                        D_o    <= {d_bit, res_sr[WIDTH-1:1]};
                        Bout_o <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        Ovf_o  <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing D = A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. Operands are captured on a start handshake and shifted through internal registers; the result and borrow-out are presented with a one-cycle done pulse. It is the subtract-direction counterpart of the combinational full adder, used where area matters more than latency.

## Interface

- WIDTH, 8, operand and result width in bits (≥ 2)
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE
- A_i  input  WIDTH  minuend, captured when start is accepted
- B_i  input  WIDTH  subtrahend, captured when start is accepted
- Bin_i  input  1  borrow-in, captured when start is accepted
- busy_o  output  1  high while bits are being processed (RUN)
- done_o  output  1  one-cycle pulse: result valid
- D_o  output  WIDTH  difference, held until next completion
- Bout_o  output  1  final borrow-out, held with D_o

## Operation

- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start_i=1 at an edge → load a_sr=A_i, b_sr=B_i, br=Bin_i, cnt=0, go RUN. start_i=0 → stay.
- RUN, each cycle: a=a_sr[0], b=b_sr[0]; d=a^b^br; br'=(~a&b)|(~(a^b)&br); d shifted into res_sr MSB side (res_sr ← {d, res_sr[WIDTH-1:1]}); a_sr, b_sr shift right; cnt++. After cnt reaches WIDTH−1 processed → DONE.
- DONE: D_o ← res_sr, Bout_o ← br (registered on RUN→DONE transition); done_o=1; next edge → IDLE unconditionally.
- start_i in RUN or DONE ignored (not queued); A_i/B_i/Bin_i changes after capture have no effect.
- Arithmetic: result is (A − B − Bin) mod 2^WIDTH; Bout_o=1 iff A < B + Bin (unsigned).
- cnt width: $clog2(WIDTH) bits (minimum 1).

## Timing

- Reset values: busy_o=0, done_o=0, D_o=0, Bout_o=0, state IDLE, cnt=0, all shift regs 0.
- Start accepted at edge k → busy_o high cycles k+1..k+WIDTH; done_o high in cycle k+WIDTH+1 only; D_o/Bout_o change at edge k+WIDTH.
- Earliest next start accepted at edge k+WIDTH+2 (first IDLE cycle); throughput one operation per WIDTH+2 cycles.
- busy_o and done_o never high together.
- D_o/Bout_o stable from done pulse until next completion; not disturbed during a subsequent RUN.
- rst_i mid-RUN or in DONE: next edge forces IDLE, clears all outputs including D_o; no done pulse for the aborted operation.
- rst_i and start_i together: reset wins; start not accepted.

## Configuration

- SERIAL_SUB_OVF_EN defined: adds output Ovf_o (1 bit), two's-complement overflow = A[MSB]^B[MSB] & (D[MSB]^A[MSB]) of the captured operands and result; registered with D_o, reset 0, held with D_o.
- Not defined: Ovf_o port absent; MSB operand bits not retained beyond shifting; all other behaviour identical.

## Test plan

- WIDTH=8, A=0x05, B=0x03, Bin=0, start pulse → busy_o 8 cycles, done_o in 9th cycle, D_o=0x02, Bout_o=0.
- A=0x03, B=0x05, Bin=0 → D_o=0xFE, Bout_o=1; A=0x00, B=0x00, Bin=1 → D_o=0xFF, Bout_o=1.
- start_i held high continuously with A=0x10, B=0x01 → operations complete every 10 cycles, each D_o=0x0F; changing A_i mid-RUN does not alter result.
- rst_i asserted at 4th RUN cycle → next cycle busy_o=0, D_o=0x00, no done_o; following start completes normally.
- rst_i and start_i both high in IDLE → remains IDLE, busy_o=0 next cycle.
- With SERIAL_SUB_OVF_EN: A=0x80, B=0x01 → D_o=0x7F, Ovf_o=1, Bout_o=0; A=0x05, B=0x03 → Ovf_o=0.
